axis_rr_arbiter: RTL

- Packet-level round-robin arbiter and mux: NUM_PORTS AXI-Stream slave inputs share one AXI-Stream master output.
- Grant is held from the first beat of a packet until its tlast handshake, so packets never interleave.
- Output is one registered stage with full-throughput backpressure.
- Sits in front of a shared AXI-Stream consumer (DMA, network egress) in both synthesis and testbench topologies.

---
 rtl/axis_rr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter and mux for AXI-Stream.
// NUM_PORTS slave streams share one registered master output stage.
// A grant is held from the first beat of a packet until its tlast handshake.
module axis_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_PORTS  = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    s_tdata,
    input  logic [NUM_PORTS-1:0]               s_tvalid,
    input  logic [NUM_PORTS-1:0]               s_tlast,
    output logic [NUM_PORTS-1:0]               s_tready,
    output logic [DATA_WIDTH-1:0]              m_tdata,
    output logic                               m_tvalid,
    output logic                               m_tlast,
    input  logic                               m_tready,
    output logic                               grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0]       grant_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   grant_d;

    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               winner_found;

    logic [DATA_WIDTH-1:0] sel_data;
    logic               sel_valid;
    logic               sel_last;

    logic               out_free_c;
    logic               load_c;

    // Output register can take a beat when empty or draining this cycle
    assign out_free_c  = !m_tvalid || m_tready;

    assign grant_valid = (state_q == ST_BUSY);
    assign grant_idx   = grant_q;

    // Round-robin scan starting one past the most recent grantee, with wrap
    always_comb begin
        winner       = grant_q;
        winner_found = 1'b0;
        cand         = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((32'(grant_q) + k) % NUM_PORTS);
            if (!winner_found && s_tvalid[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Select the granted port's beat
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    // Next-state, grant update and per-port ready generation
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        s_tready = '0;
        load_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (winner_found) begin
                    state_d = ST_BUSY;
                    grant_d = winner;
                end
            end
            ST_BUSY: begin
                s_tready[grant_q] = out_free_c;
                if (sel_valid && out_free_c) begin
                    load_c = 1'b1;
                    if (sel_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and grant registers; port 0 gets first priority out of reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Output stage: load on input handshake, clear on drain, hold while stalled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (load_c) begin
            m_tdata  <= sel_data;
            m_tlast  <= sel_last;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule
